// File: rtl/float32_pkg.sv
// Shared float32 field layout, subnormal detection and row-collector FSM states.
package float32_pkg;

  localparam int unsigned FLOAT32_W = 32;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned MANT_W    = 23;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } float32_t;

  typedef enum logic {
    COLLECT,
    PRESENT
  } row_state_e;

  function automatic logic is_subnormal(input float32_t f);
    return (f.exp == '0) && (f.mant != '0);
  endfunction

endpackage

// File: rtl/sum_valid_delay.sv
// Fixed-depth 1-bit strobe delay line; keeps side-band valids aligned with pipelined datapaths.
module sum_valid_delay #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [Depth-1:0] r_pipe;

  generate
    if (Depth == 1) begin : g_single
      always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) r_pipe <= '0;
        else        r_pipe <= d_i;
      end
    end else begin : g_shift
      always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) r_pipe <= '0;
        else        r_pipe <= {r_pipe[Depth-2:0], d_i};
      end
    end
  endgenerate

  assign q_o = r_pipe[Depth-1];

endmodule

// File: rtl/row_collector_float32.sv
// Packs a float32 stream into zero-padded rows for the adder tree.
// Optional subnormal flush-to-signed-zero: define ROW_COLLECTOR_DENORM_FLUSH_EN.
module row_collector_float32
  import float32_pkg::*;
#(
  parameter int unsigned NUMBER_OF_INPUTS = 1024,
  parameter int unsigned BITS_PER_SYMBOL  = 32,
  parameter int unsigned TREE_LATENCY     = $clog2(NUMBER_OF_INPUTS)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_n,
  input  logic [BITS_PER_SYMBOL-1:0]              s_data_i,
  input  logic                                    s_valid_i,
  input  logic                                    s_last_i,
  output logic                                    s_ready_o,
  output logic [NUMBER_OF_INPUTS*BITS_PER_SYMBOL-1:0] row_o,
  output logic                                    row_valid_o,
  output logic [$clog2(NUMBER_OF_INPUTS):0]       lanes_o,
  output logic                                    sum_valid_o
);

  localparam int unsigned IDX_W = $clog2(NUMBER_OF_INPUTS);
  localparam int unsigned ROW_W = NUMBER_OF_INPUTS * BITS_PER_SYMBOL;

  row_state_e                 r_state, w_state_next;
  logic [IDX_W-1:0]           r_idx;
  logic [IDX_W:0]             r_lanes;
  logic [ROW_W-1:0]           r_row;
  logic                       w_xfer;
  logic                       w_close;
  logic [BITS_PER_SYMBOL-1:0] w_word;

`ifdef ROW_COLLECTOR_DENORM_FLUSH_EN
  float32_t w_in;
  assign w_in   = s_data_i;
  assign w_word = is_subnormal(w_in) ? {w_in.sign, {(FLOAT32_W-1){1'b0}}} : s_data_i;
`else
  assign w_word = s_data_i;
`endif

  assign w_xfer  = s_valid_i && s_ready_o;
  assign w_close = s_last_i || (r_idx == IDX_W'(NUMBER_OF_INPUTS - 1));

  always_comb begin
    w_state_next = r_state;
    s_ready_o    = 1'b0;
    row_valid_o  = 1'b0;
    unique case (r_state)
      COLLECT: begin
        s_ready_o = 1'b1;
        if (w_xfer && w_close) w_state_next = PRESENT;
      end
      PRESENT: begin
        row_valid_o  = 1'b1;
        w_state_next = COLLECT;
      end
    endcase
  end

  // Clearing the buffer when a row leaves is what provides zero padding for the next short row.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
      r_idx   <= '0;
      r_lanes <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == PRESENT) begin
        r_row <= '0;
        r_idx <= '0;
      end else if (w_xfer) begin
        r_row[r_idx*BITS_PER_SYMBOL +: BITS_PER_SYMBOL] <= w_word;
        r_idx <= r_idx + 1'b1;
        if (w_close) r_lanes <= {1'b0, r_idx} + (IDX_W+1)'(1);
      end
    end
  end

  assign row_o   = r_row;
  assign lanes_o = r_lanes;

  sum_valid_delay #(
    .Depth (TREE_LATENCY)
  ) u_sum_valid_delay (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .d_i   (row_valid_o),
    .q_o   (sum_valid_o)
  );

endmodule

// File: tb/tb_row_collector_float32.sv
// Scoreboard bench for row_collector_float32 with N=4 lanes and a 2-stage tree latency.
module tb_row_collector_float32;

  localparam int unsigned N  = 4;
  localparam int unsigned TL = 2;
  localparam int unsigned W  = 32;
  localparam int unsigned RW = N * W;
  localparam int unsigned LW = $clog2(N) + 1;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  s_data_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_last_i = 1'b0;
  logic          s_ready_o;
  logic [RW-1:0] row_o;
  logic          row_valid_o;
  logic [LW-1:0] lanes_o;
  logic          sum_valid_o;

  row_collector_float32 #(
    .NUMBER_OF_INPUTS (N),
    .BITS_PER_SYMBOL  (W),
    .TREE_LATENCY     (TL)
  ) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .s_data_i    (s_data_i),
    .s_valid_i   (s_valid_i),
    .s_last_i    (s_last_i),
    .s_ready_o   (s_ready_o),
    .row_o       (row_o),
    .row_valid_o (row_valid_o),
    .lanes_o     (lanes_o),
    .sum_valid_o (sum_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [LW-1:0] lanes;
  } exp_t;

  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  exp_t          exp_q[$];
  int            sum_q[$];
  int            rv_t[$];
  int            sv_t[$];
  logic [RW-1:0] m_row = '0;
  int            m_idx = 0;
  int            last_wait = 0;
  exp_t          mon_e;
  int            mon_t;

  task automatic check_eq(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model_word(input logic [W-1:0] d);
`ifdef ROW_COLLECTOR_DENORM_FLUSH_EN
    if (d[30:23] == 8'h00 && d[22:0] != 23'h0) return {d[31], 31'b0};
`endif
    return d;
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (rst_n) begin
      if (row_valid_o) begin
        rv_t.push_back(cyc);
        check_eq("present_ready_low", RW'(s_ready_o), RW'(0));
        if (exp_q.size() == 0) begin
          check_eq("row_unexpected", RW'(row_valid_o), RW'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("row_data", row_o, mon_e.row);
          check_eq("row_lanes", RW'(lanes_o), RW'(mon_e.lanes));
          sum_q.push_back(cyc + TL);
        end
      end
      if (sum_valid_o) begin
        sv_t.push_back(cyc);
        if (sum_q.size() == 0) begin
          check_eq("sum_unexpected", RW'(sum_valid_o), RW'(0));
        end else begin
          mon_t = sum_q.pop_front();
          check_eq("sum_align", RW'(cyc), RW'(mon_t));
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic last);
    bit acc;
    int n;
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = last;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk_i);
      acc = s_ready_o;
      @(posedge clk_i);
      n++;
    end
    last_wait = n;
    #1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    if (!acc) begin
      check_eq("send_timeout", RW'(s_ready_o), RW'(1));
    end else begin
      m_row[m_idx*W +: W] = model_word(d);
      m_idx++;
      if (last || m_idx == N) begin
        exp_q.push_back({m_row, LW'(m_idx)});
        m_row = '0;
        m_idx = 0;
        check_eq("row_latency", RW'(row_valid_o), RW'(1));
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    sum_q.delete();
    m_row = '0;
    m_idx = 0;
    #2;
    check_eq("rst_row", row_o, RW'(0));
    check_eq("rst_row_valid", RW'(row_valid_o), RW'(0));
    check_eq("rst_lanes", RW'(lanes_o), RW'(0));
    check_eq("rst_sum_valid", RW'(sum_valid_o), RW'(0));
    check_eq("rst_ready", RW'(s_ready_o), RW'(1));
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Full row
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    send(32'h40400000, 1'b0);
    send(32'h40800000, 1'b0);
    check_eq("full_row_literal", row_o, 128'h40800000_40400000_40000000_3F800000);
    idle(4);

    // Short row
    send(32'h40A00000, 1'b1);
    check_eq("short_row_literal", row_o, 128'h0_40A00000);
    check_eq("short_lanes", RW'(lanes_o), RW'(1));
    idle(4);

    // Backpressure: word held valid through PRESENT lands in lane 0 of next row
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b1);
    check_eq("bp_ready_low", RW'(s_ready_o), RW'(0));
    send(32'h3F800000, 1'b0);
    check_eq("bp_wait_cycles", RW'(last_wait), RW'(2));
    send(32'h40000000, 1'b1);
    idle(4);

    // Random gaps and lengths
    for (int r = 0; r < 4; r++) begin
      int len;
      len = $urandom_range(1, N);
      for (int k = 0; k < len; k++) begin
        send($urandom, (k == len - 1));
        idle($urandom_range(0, 2));
      end
      idle(3);
    end

    // Back-to-back full rows
    rv_t.delete();
    sv_t.delete();
    for (int k = 0; k < 2 * N; k++) send(32'h40000000 + k, 1'b0);
    idle(6);
    check_eq("b2b_row_count", RW'(rv_t.size()), RW'(2));
    check_eq("b2b_sum_count", RW'(sv_t.size()), RW'(2));
    if (rv_t.size() == 2) check_eq("b2b_row_spacing", RW'(rv_t[1] - rv_t[0]), RW'(N + 1));
    if (sv_t.size() == 2) check_eq("b2b_sum_spacing", RW'(sv_t[1] - sv_t[0]), RW'(N + 1));

    // Reset mid-row
    send(32'hAAAA0001, 1'b0);
    send(32'hAAAA0002, 1'b0);
    do_reset();
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    send(32'h40400000, 1'b1);
    idle(4);

    // Reset one cycle after row_valid suppresses the pending sum strobe
    send(32'h40A00000, 1'b1);
    idle(1);
    sv_t.delete();
    do_reset();
    idle(6);
    check_eq("sum_suppressed", RW'(sv_t.size()), RW'(0));

    // Subnormal input
    send(32'h80000001, 1'b1);
`ifdef ROW_COLLECTOR_DENORM_FLUSH_EN
    check_eq("denorm_lane0", RW'(row_o[W-1:0]), RW'(32'h80000000));
`else
    check_eq("denorm_lane0", RW'(row_o[W-1:0]), RW'(32'h80000001));
`endif
    idle(6);

    check_eq("rows_outstanding", RW'(exp_q.size()), RW'(0));
    check_eq("sums_outstanding", RW'(sum_q.size()), RW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
